ball_engine: RTL

BALL_ENGINE -- requirements
Module: ball_engine

---
 rtl/ball_engine.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ball_engine.sv
// ----------------------------------------------------------------------------
// ball_engine
//
// Purpose:
//   Moves a ball around a WIDTH x HEIGHT screen. It bounces off the left,
//   right and top walls and off a player paddle. When the ball passes the
//   paddle and reaches the floor, the block reports a miss and recentres
//   the ball. The ball moves once every TICK_DIV clock cycles, and only
//   while the block is in the MOVE state.
//
// Optional feature (macro BALL_SPEEDUP_EN):
//   When defined, every 4th paddle hit raises the per-tick step by one
//   pixel, up to MAX_STEP. A miss returns the step to STEP. When the macro
//   is undefined, the step stays at STEP permanently.
//
// Ports:
//   clk                      system clock; all state changes on its rising edge
//   reset                    synchronous, active-high reset
//   start                    launch request; only acted on in IDLE
//   paddle_left/right [XW]   inclusive x span of the paddle
//   paddle_top        [YW]   top row of the paddle
//   ball_x [XW], ball_y [YW] ball centre
//   active                   high while the ball is in play (MOVE)
//   hit / miss               one-cycle pulses for a paddle bounce / floor miss
//   hits [8]                 paddle-hit count; saturates at 255 and is not
//                            cleared by a miss
// ----------------------------------------------------------------------------
module ball_engine #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int RADIUS   = 10,
    parameter int TICK_DIV = 1000000,
    parameter int STEP     = 2,
    parameter int MAX_STEP = 6,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] paddle_left,
    input  logic [XW-1:0] paddle_right,
    input  logic [YW-1:0] paddle_top,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic          active,
    output logic          hit,
    output logic          miss,
    output logic [7:0]    hits
);

    // The counter needs at least one bit, even when TICK_DIV is 1.
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // The step register is sized to hold the larger of STEP and MAX_STEP.
    localparam int SMAX = (MAX_STEP > STEP) ? MAX_STEP : STEP;
    localparam int SW   = $clog2(SMAX + 1);
    // Extended widths give the bounds arithmetic one bit of headroom.
    localparam int XE = XW + 1;
    localparam int YE = YW + 1;

    localparam logic [CW-1:0] CNT_LAST    = CW'(TICK_DIV - 1);
    localparam logic [XW-1:0] X_CENTRE    = XW'(WIDTH / 2);
    localparam logic [YW-1:0] Y_CENTRE    = YW'(HEIGHT / 2);
    localparam logic [XW-1:0] X_RIGHT_POS = XW'(WIDTH - 1 - RADIUS);
    localparam logic [XW-1:0] X_LEFT_POS  = XW'(RADIUS);
    localparam logic [YW-1:0] Y_TOP_POS   = YW'(RADIUS);
    localparam logic [XE-1:0] X_RIGHT_LIM = XE'(WIDTH - 1);
    localparam logic [YE-1:0] Y_FLOOR     = YE'(HEIGHT - 1);
    localparam logic [XE-1:0] RAD_X       = XE'(RADIUS);
    localparam logic [YE-1:0] RAD_Y       = YE'(RADIUS);
    localparam logic [SW-1:0] STEP_INIT   = SW'(STEP);

    typedef enum logic [1:0] {IDLE, MOVE, MISS} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;
    logic          dx_reg, dx_next;
    logic          dy_reg, dy_next;
    logic [7:0]    hits_reg, hits_next;
    logic          hit_reg, hit_next;
    logic          miss_reg, miss_next;
    logic          active_reg, active_next;
    logic [SW-1:0] step_cur;

`ifdef BALL_SPEEDUP_EN
    localparam logic [SW-1:0] STEP_CEIL = SW'(MAX_STEP);
    logic [SW-1:0] step_reg, step_next;
    assign step_cur = step_reg;
`else
    assign step_cur = STEP_INIT;
`endif

    // Bounds arithmetic is done at the extended width.
    logic          tick;
    logic [XE-1:0] x_e, sx;
    logic [YE-1:0] y_e, sy, top_e;
    logic          paddle_span, paddle_bounce, floor_miss;

    assign tick  = (state_reg == MOVE) && (cnt_reg == CNT_LAST);
    assign x_e   = {1'b0, x_reg};
    assign y_e   = {1'b0, y_reg};
    assign sx    = XE'(step_cur);
    assign sy    = YE'(step_cur);
    assign top_e = {1'b0, paddle_top};

    // The paddle is tested against the ball's position before the step.
    // The bounce applies when this step carries the ball's lower edge from
    // above the paddle top to on or below it.
    assign paddle_span   = (paddle_left <= x_reg) && (x_reg <= paddle_right);
    assign paddle_bounce = dy_reg && (y_e + RAD_Y <= top_e)
                           && (y_e + sy + RAD_Y >= top_e) && paddle_span;
    assign floor_miss    = dy_reg && !paddle_bounce
                           && (y_e + sy + RAD_Y >= Y_FLOOR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            x_reg      <= X_CENTRE;
            y_reg      <= Y_CENTRE;
            dx_reg     <= 1'b1;
            dy_reg     <= 1'b0;
            hits_reg   <= 8'd0;
            hit_reg    <= 1'b0;
            miss_reg   <= 1'b0;
            active_reg <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            step_reg   <= STEP_INIT;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            dx_reg     <= dx_next;
            dy_reg     <= dy_next;
            hits_reg   <= hits_next;
            hit_reg    <= hit_next;
            miss_reg   <= miss_next;
            active_reg <= active_next;
`ifdef BALL_SPEEDUP_EN
            step_reg   <= step_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        x_next     = x_reg;
        y_next     = y_reg;
        dx_next    = dx_reg;
        dy_next    = dy_reg;
        hits_next  = hits_reg;
        hit_next   = 1'b0;
        miss_next  = 1'b0;
`ifdef BALL_SPEEDUP_EN
        step_next  = step_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = MOVE;
                end
            end

            MOVE: begin
                // The counter stays at zero outside MOVE, so each launch
                // starts a full tick period.
                cnt_next = tick ? '0 : cnt_reg + CW'(1);

                if (tick) begin
                    // Horizontal axis.
                    if (dx_reg) begin
                        if (x_e + sx + RAD_X >= X_RIGHT_LIM) begin
                            x_next  = X_RIGHT_POS;
                            dx_next = 1'b0;
                        end else begin
                            x_next = XW'(x_e + sx);
                        end
                    end else begin
                        // Checking before subtracting prevents underflow.
                        if (x_e < RAD_X + sx) begin
                            x_next  = X_LEFT_POS;
                            dx_next = 1'b1;
                        end else begin
                            x_next = XW'(x_e - sx);
                        end
                    end

                    // Vertical axis. It is evaluated independently of the
                    // horizontal axis, so a corner reflects both at once.
                    if (!dy_reg) begin
                        if (y_e < RAD_Y + sy) begin
                            y_next  = Y_TOP_POS;
                            dy_next = 1'b1;
                        end else begin
                            y_next = YW'(y_e - sy);
                        end
                    end else if (paddle_bounce) begin
                        y_next   = YW'(top_e - RAD_Y);
                        dy_next  = 1'b0;
                        hit_next = 1'b1;
                        if (hits_reg != 8'hFF) begin
                            hits_next = hits_reg + 8'd1;
`ifdef BALL_SPEEDUP_EN
                            // Speed up when the low two bits of the new
                            // count roll over to zero (every 4th hit).
                            if ((hits_reg[1:0] == 2'b11) && (step_reg < STEP_CEIL)) begin
                                step_next = step_reg + SW'(1);
                            end
`endif
                        end
                    end else if (floor_miss) begin
                        // The recentre overrides the horizontal update above.
                        state_next = MISS;
                        miss_next  = 1'b1;
                        x_next     = X_CENTRE;
                        y_next     = Y_CENTRE;
                        dx_next    = 1'b1;
                        dy_next    = 1'b0;
`ifdef BALL_SPEEDUP_EN
                        step_next  = STEP_INIT;
`endif
                    end else begin
                        y_next = YW'(y_e + sy);
                    end
                end
            end

            MISS: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        active_next = (state_next == MOVE);
    end

    assign ball_x = x_reg;
    assign ball_y = y_reg;
    assign active = active_reg;
    assign hit    = hit_reg;
    assign miss   = miss_reg;
    assign hits   = hits_reg;

endmodule
